// File: rtl/reg_file_wb_pkg.sv
// ============================================================================
// Module : reg_file_wb_pkg
// Brief  : Shared widths and types for the register file and its neighbours.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package reg_file_wb_pkg;

    localparam int REG_DATA_W   = 8;
    localparam int REG_ADDR_W   = 4;
    localparam int REG_NUM_REGS = 2 ** REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_bypass.sv
// ============================================================================
// Module : reg_file_bypass
// Brief  : Read-port priority selector: live write, then write-back reg, then array.
//          REG_FILE_R0_ZERO_EN forces address 0 to read as zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_bypass
    import reg_file_wb_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] array_q,
    output logic [DATA_W-1:0] rd_data
);

    always_comb begin
        rd_data = array_q;
`ifdef REG_FILE_R0_ZERO_EN
        if (rd_addr == '0) begin
            rd_data = '0;
        end else
`endif
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end else if (wb_valid && (wb_addr == rd_addr)) begin
            rd_data = wb_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_file_wb.sv
// ============================================================================
// Module : reg_file_wb
// Brief  : Register file with a one-entry write-back stage and full read bypass.
//          Optional macro REG_FILE_R0_ZERO_EN hardwires register 0 to zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_wb
    import reg_file_wb_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              wb_busy
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_wb_valid;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              w_wb_accept;

    // Writes to register 0 never enter the pipeline when it is hardwired.
`ifdef REG_FILE_R0_ZERO_EN
    assign w_wb_accept = wr_en && (wr_addr != '0);
`else
    assign w_wb_accept = wr_en;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wb_valid <= w_wb_accept;
            r_wb_addr  <= wr_addr;
            r_wb_data  <= wr_data;
            if (r_wb_valid) begin
                r_regs[r_wb_addr] <= r_wb_data;
            end
        end
    end

    assign wb_busy = r_wb_valid;

    reg_file_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bypass_a (
        .rd_addr  (rd_addr_a),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wb_valid (r_wb_valid),
        .wb_addr  (r_wb_addr),
        .wb_data  (r_wb_data),
        .array_q  (r_regs[rd_addr_a]),
        .rd_data  (rd_data_a)
    );

    reg_file_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bypass_b (
        .rd_addr  (rd_addr_b),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wb_valid (r_wb_valid),
        .wb_addr  (r_wb_addr),
        .wb_data  (r_wb_data),
        .array_q  (r_regs[rd_addr_b]),
        .rd_data  (rd_data_b)
    );

endmodule

`default_nettype wire
